// File: rtl/code_mem_loader.sv
// Code memory loader: receives a length-prefixed, checksummed byte stream and writes
// the payload into byte-wide code memory, holding the CPU in reset until a good load.
module code_mem_loader #(
  parameter int MEM_SIZE = 256,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  // Byte counter is wide enough to hold 4 * (16-bit word count) without wrapping.
  localparam int             CNT_W     = 18;
  localparam logic [15:0]    MAX_WORDS = 16'(MEM_SIZE);

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         sum_q, sum_d;
  logic [15:0]        words_q, words_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               hold_q, hold_d;

  logic               xfer;
  logic [15:0]        len_full;
  logic [CNT_W-1:0]   last_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      words_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      hold_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      words_q     <= words_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    words_d     = words_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    hold_d      = hold_q;

    in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                (state_q == S_DATA)   || (state_q == S_CHECK);
    xfer      = in_valid && in_ready;
    len_full  = {in_data, len_q[7:0]};
    last_byte = {len_q, 2'b00} - CNT_W'(1);

    case (state_q)
      // A new load wipes all per-load state and re-asserts the CPU hold.
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
          words_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          hold_d  = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = {8'h00, in_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      // The write lands one cycle after the accept, addressed by the pre-increment count.
      S_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          sum_d       = sum_q + in_data;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q[1:0] == 2'b11) begin
            words_d = words_q + 16'd1;
          end
          if (cnt_q == last_byte) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign cpu_reset_hold = hold_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_code_mem_loader.sv
// Self-checking bench for code_mem_loader: directed and random frames checked against
// a frame-level reference model (length, payload sum, expected writes).
module tb_code_mem_loader;

   localparam int MEM_SIZE = 256;
   localparam int ADDR_W   = 10;
   localparam int BYTES    = MEM_SIZE * 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              inValid;
   logic [7:0]        inData;
   logic              inReady;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [7:0]        memWdata;
   logic              cpuResetHold;
   logic              done;
   logic              error;
   logic [15:0]       wordsLoaded;

   int total = 0;
   int bad = 0;
   int weCount = 0;
   logic [7:0] shadowMem [BYTES];
   logic [7:0] frameQ [$];
   bit sentOk;

   code_mem_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .in_valid(inValid),
      .in_data(inData),
      .in_ready(inReady),
      .mem_we(memWe),
      .mem_addr(memAddr),
      .mem_wdata(memWdata),
      .cpu_reset_hold(cpuResetHold),
      .done(done),
      .error(error),
      .words_loaded(wordsLoaded)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Observe the memory write port away from the active edge and keep a shadow image
   // of code memory plus a running count of write strobes.
   always @(negedge clk) begin
      if (memWe === 1'b1) begin
         weCount <= weCount + 1;
         shadowMem[memAddr] <= memWdata;
      end
   end

   // Safety net so a wedged run still terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts, and reports any mismatch through the assertion.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every output must sit at its reset value.
   task automatic checkReset(input string tag);
      checkOutput({tag, "_in_ready"}, inReady, 0);
      checkOutput({tag, "_mem_we"}, memWe, 0);
      checkOutput({tag, "_mem_addr"}, memAddr, 0);
      checkOutput({tag, "_mem_wdata"}, memWdata, 0);
      checkOutput({tag, "_hold"}, cpuResetHold, 1);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_error"}, error, 0);
      checkOutput({tag, "_words"}, wordsLoaded, 0);
   endtask

   // Pulse start for one cycle (optionally with a junk byte offered at the same time).
   task automatic startLoad(input bit withValid);
      start = 1'b1;
      if (withValid) begin
         inValid = 1'b1;
         inData  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      start   = 1'b0;
      inValid = 1'b0;
      @(negedge clk);
      checkOutput("start_ready", inReady, 1);
      checkOutput("start_hold", cpuResetHold, 1);
      checkOutput("start_done", done, 0);
      checkOutput("start_error", error, 0);
      checkOutput("start_words", wordsLoaded, 0);
   endtask

   // Offer one byte after 'gap' idle cycles, wait for the accept, then check the write
   // that must (or must not) appear in the following cycle.
   task automatic applyStimulus(input logic [7:0] b, input int gap, input bit isData, input int addr);
      int waits;
      inValid = 1'b0;
      repeat (gap) @(negedge clk);
      inValid = 1'b1;
      inData  = b;
      waits   = 0;
      while (inReady !== 1'b1 && waits < 64) begin
         @(negedge clk);
         waits++;
      end
      checkOutput("accept_ready", inReady, 1);
      if (inReady !== 1'b1) begin
         inValid = 1'b0;
         sentOk  = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inData  = 8'($urandom);
      @(negedge clk);
      checkOutput("write_strobe", memWe, isData);
      if (isData) begin
         checkOutput("write_addr", memAddr, addr);
         checkOutput("write_data", memWdata, b);
      end
      sentOk = 1'b1;
   endtask

   // Build a frame of n words with random payload; corrupt spoils the checksum byte.
   task automatic buildFrame(input int n, input bit corrupt);
      logic [7:0] s;
      frameQ.delete();
      frameQ.push_back(8'(n));
      frameQ.push_back(8'(n >> 8));
      if (n <= MEM_SIZE) begin
         s = 8'h00;
         for (int k = 0; k < 4 * n; k++) begin
            frameQ.push_back(8'($urandom));
            s = s + frameQ[2 + k];
         end
         frameQ.push_back(corrupt ? (s ^ 8'(1 + $urandom_range(0, 254))) : s);
      end
   endtask

   // Reference model: decide the frame outcome from its bytes, drive it, then check
   // status, write count and memory image against that outcome.
   task automatic runFrame(input int gapMode, input bit withValid);
      int n;
      int nBytes;
      int weBase;
      int gap;
      int mism;
      bit oversize;
      bit good;
      logic [7:0] sum;
      n        = int'({frameQ[1], frameQ[0]});
      oversize = (n > MEM_SIZE);
      sum      = 8'h00;
      if (!oversize) begin
         for (int k = 0; k < 4 * n; k++) sum = sum + frameQ[2 + k];
      end
      good   = !oversize && (frameQ[2 + 4 * n] == sum);
      nBytes = oversize ? 2 : 4 * n + 3;
      weBase = weCount;
      startLoad(withValid);
      for (int idx = 0; idx < nBytes; idx++) begin
         gap = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 3)) : 0;
         applyStimulus(frameQ[idx], gap, (idx >= 2) && (idx < 2 + 4 * n), idx - 2);
         if (!sentOk) return;
      end
      @(negedge clk);
      checkOutput("end_in_ready", inReady, 0);
      checkOutput("end_done", done, good);
      checkOutput("end_error", error, !good);
      checkOutput("end_hold", cpuResetHold, !good);
      checkOutput("end_words", wordsLoaded, oversize ? 0 : n);
      checkOutput("end_write_count", weCount - weBase, oversize ? 0 : 4 * n);
      if (!oversize) begin
         mism = 0;
         for (int k = 0; k < 4 * n; k++) begin
            if (shadowMem[k] !== frameQ[2 + k]) mism++;
         end
         checkOutput("mem_image", mism, 0);
      end
   endtask

   // Directed steps first, then a batch of random frames.
   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      inValid = 1'b0;
      inData  = 8'h00;
      repeat (3) @(negedge clk);
      checkReset("por");
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready", inReady, 0);

      $display("[TB] single word frame");
      frameQ = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8};
      runFrame(0, 1'b1);

      $display("[TB] two words, valid toggling");
      buildFrame(2, 1'b0);
      runFrame(1, 1'b0);

      $display("[TB] bad checksum");
      frameQ = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      runFrame(0, 1'b0);

      $display("[TB] oversize length 257");
      frameQ = '{8'h01, 8'h01};
      runFrame(0, 1'b0);

      $display("[TB] empty frame");
      frameQ = '{8'h00, 8'h00, 8'h00};
      runFrame(0, 1'b0);

      $display("[TB] empty frame, wrong checksum");
      frameQ = '{8'h00, 8'h00, 8'h5A};
      runFrame(0, 1'b0);

      $display("[TB] reset mid-load");
      buildFrame(2, 1'b0);
      startLoad(1'b0);
      for (int idx = 0; idx < 5; idx++) begin
         applyStimulus(frameQ[idx], 0, idx >= 2, idx - 2);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkReset("midreset");
      buildFrame(3, 1'b0);
      runFrame(2, 1'b0);

      $display("[TB] maximum length frame");
      buildFrame(MEM_SIZE, 1'b0);
      runFrame(0, 1'b0);

      $display("[TB] length 0xFFFF");
      frameQ = '{8'hFF, 8'hFF};
      runFrame(0, 1'b0);

      $display("[TB] random frames");
      for (int r = 0; r < 10; r++) begin
         buildFrame(int'($urandom_range(0, 12)), $urandom_range(0, 3) == 0);
         runFrame(2, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
